muxn_scan_reg: RTL and testbench
================================

// Module: muxn_scan_reg
// PURPOSE
//  Parametrised, registered N:1 multiplexer; next generation of the 4:1 select mux.
//  Two selection modes: manual (external sel) and scan (internal channel counter,
//  fixed dwell per channel). Output is registered behind a valid/ready handshake.
//  Sits between parallel sample sources and one downstream serial consumer.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  NCH    4  number of input channels, 2..256
//  SELW   2  select/channel-index width, must satisfy 2**SELW >= NCH
//  DWELL  4  accepted samples per channel in scan mode before advancing, >=1
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  mode       in   1           0 = manual (use sel), 1 = scan (internal counter)
//  sel        in   SELW        manual channel select
//  d          in   NCH*WIDTH   channel k at d[k*WIDTH +: WIDTH]
//  out_ready  in   1           downstream accepts q this cycle
//  q          out  WIDTH       registered selected data
//  q_valid    out  1           q holds a sample not yet accepted
//  q_ch       out  SELW        channel index q was taken from
//  sel_err    out  1           sample in q came from an out-of-range manual sel
//  q_par      out  1           even parity of q (MUXN_PARITY_EN only)
// BEHAVIOUR
//  - Reset (reset=1 at clk edge): q=0, q_valid=0, q_ch=0, sel_err=0, q_par=0,
//    scan ch_cnt=0, dwell_cnt=0, state=IDLE. Reset overrides all other inputs.
//  - load = !q_valid || out_ready (register empty or being drained this cycle).
//  - accept = q_valid && out_ready.
//  - On load, next cycle q=d[cur*WIDTH +: WIDTH], q_ch=cur, q_valid=1. Latency 1 clk,
//    one sample per clk under continuous out_ready. No load -> q, q_ch, sel_err held
//    stable (no combinational path from d to q).
//  - cur = sel in manual mode, ch_cnt in scan mode.
//  - Manual, sel >= NCH: load channel 0 data, q_ch=sel, sel_err=1 for that sample.
//    Otherwise sel_err=0.
//  - FSM: IDLE -> MAN or SCAN on the first cycle after reset (per mode); q_valid=0 in IDLE.
//    MAN -> SCAN when mode=1: ch_cnt=0, dwell_cnt=0. The load in the switch cycle
//    already uses channel 0.
//    SCAN -> MAN when mode=0: counters frozen. The load in that cycle uses sel.
//  - Scan counting: each load increments dwell_cnt. When dwell_cnt==DWELL-1, dwell_cnt
//    wraps to 0 and ch_cnt advances. ch_cnt wraps NCH-1 -> 0. No load -> counters hold.
//  - Backpressure: q_valid=1 with out_ready=0 holds everything. No sample dropped or
//    duplicated.
//  - Mode or sel change while stalled: takes effect at the next load only.
//  - Reset mid-stream: pending sample discarded; q_valid=0 the cycle after reset.
// CONFIGURATION
//  - MUXN_PARITY_EN defined: q_par registered with q on every load, q_par = ^q.
//    Reset value 0.
//  - Not defined: q_par port absent. No parity logic.
// TESTING
//  1 Reset: reset=1 for 2 clk, out_ready=1
//    -> q=0, q_valid=0, q_ch=0, sel_err=0. First q_valid=1 two clks after reset drop.
//  2 Manual NCH=4, WIDTH=8: d={8'h44,8'h33,8'h22,8'h11}; sel=0,1,2,3 on consecutive clks
//    -> q=11,22,33,44 one clk later each; q_ch follows sel.
//  3 Scan DWELL=2, out_ready=1 -> q_ch sequence 0,0,1,1,2,2,3,3,0,0 (wrap checked).
//  4 Backpressure, scan mode: drop out_ready for 3 clks mid-dwell
//    -> q, q_ch stable. Resume without loss or duplication; dwell count intact.
//  5 NCH=3, manual sel=3 -> q=d[7:0], q_ch=3, sel_err=1. Next sel=1 -> sel_err=0.
//  6 MUXN_PARITY_EN: q=8'h07 -> q_par=1; q=8'h03 -> q_par=0.
//    Mode 0->1 mid-run -> next q_ch=0.

Source files
------------

// File: rtl/muxn_scan_reg.sv
// Registered N:1 mux with manual select and dwell-based channel scanning, behind a valid/ready output stage.
// Optional even-parity output q_par is compiled in when MUXN_PARITY_EN is defined.
module muxn_scan_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     q,
  output logic                 q_valid,
  output logic [SELW-1:0]      q_ch,
`ifdef MUXN_PARITY_EN
  output logic                 sel_err,
  output logic                 q_par
`else
  output logic                 sel_err
`endif
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DLAST = DW'(DWELL - 1);
  localparam logic [SELW-1:0] CLAST = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);

  typedef enum logic [1:0] {S_IDLE, S_MAN, S_SCAN} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              err_q, err_d;
  logic              par_q, par_d;

  logic              load;
  logic [SELW-1:0]   base_ch, ld_ch;
  logic [DW-1:0]     base_dwell;
  logic [WIDTH-1:0]  ld_data;

  assign load = !valid_q || out_ready;

  // Entering scan from manual restarts the count; the switching load itself is channel 0.
  assign base_ch    = (state_q == S_SCAN) ? ch_cnt_q : '0;
  assign base_dwell = (state_q == S_SCAN) ? dwell_q  : '0;

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    dwell_d  = dwell_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ch_d     = ch_q;
    err_d    = err_q;
    par_d    = par_q;
    ld_ch    = '0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        state_d = mode ? S_SCAN : S_MAN;
      end
      default: begin
        if (load) begin
          valid_d = 1'b1;
          if (mode) begin
            state_d = S_SCAN;
            ld_ch   = base_ch;
            ch_d    = base_ch;
            err_d   = 1'b0;
            if (base_dwell == DLAST) begin
              dwell_d  = '0;
              ch_cnt_d = (base_ch == CLAST) ? '0 : base_ch + 1'b1;
            end else begin
              dwell_d  = base_dwell + 1'b1;
              ch_cnt_d = base_ch;
            end
          end else begin
            state_d = S_MAN;
            ch_d    = sel;
            err_d   = ({1'b0, sel} >= NCH_W);
            ld_ch   = err_d ? '0 : sel;
          end
          data_d = ld_data;
          par_d  = ^ld_data;
        end
      end
    endcase
  end

  always_comb begin
    ld_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ld_ch == SELW'(k)) ld_data = d[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_cnt_q <= '0;
      dwell_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      err_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      dwell_q  <= dwell_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      err_q    <= err_d;
      par_q    <= par_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;
  assign q_ch    = ch_q;
  assign sel_err = err_q;
`ifdef MUXN_PARITY_EN
  assign q_par   = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_muxn_scan_reg.sv
// Directed bench for muxn_scan_reg: DUT a (NCH=4, DWELL=2) covers manual/scan/backpressure,
// DUT b (NCH=3) covers out-of-range manual select.
module tb_muxn_scan_reg;
  logic        clk = 1'b0;
  logic        reset, mode, out_ready;
  logic [1:0]  sel_a, sel_b;
  logic [31:0] d_a;
  logic [23:0] d_b;
  logic [7:0]  q_a, q_b;
  logic        v_a, v_b, e_a, e_b;
  logic [1:0]  c_a, c_b;
`ifdef MUXN_PARITY_EN
  logic        p_a, p_b;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muxn_scan_reg #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(2)) u_a (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel_a), .d(d_a), .out_ready(out_ready),
    .q(q_a), .q_valid(v_a), .q_ch(c_a),
`ifdef MUXN_PARITY_EN
    .sel_err(e_a), .q_par(p_a)
`else
    .sel_err(e_a)
`endif
  );

  muxn_scan_reg #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(4)) u_b (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel_b), .d(d_b), .out_ready(out_ready),
    .q(q_b), .q_valid(v_b), .q_ch(c_b),
`ifdef MUXN_PARITY_EN
    .sel_err(e_b), .q_par(p_b)
`else
    .sel_err(e_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; mode = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
    d_a = {8'h44, 8'h33, 8'h22, 8'h11};
    d_b = {8'hC3, 8'hB2, 8'hA1};
    tick(); tick();
    checks++; if (q_a !== 8'h00)  begin failures++; $display("FAIL reset_q got=%h exp=00", q_a); end
    checks++; if (v_a !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", v_a); end
    checks++; if (c_a !== 2'd0)   begin failures++; $display("FAIL reset_qch got=%0d exp=0", c_a); end
    checks++; if (e_a !== 1'b0)   begin failures++; $display("FAIL reset_selerr got=%b exp=0", e_a); end
    reset = 1'b0;
    tick();
    checks++; if (v_a !== 1'b0)   begin failures++; $display("FAIL idle_valid got=%b exp=0", v_a); end
    tick();
    checks++; if (v_a !== 1'b1)   begin failures++; $display("FAIL first_valid got=%b exp=1", v_a); end
    checks++; if (q_a !== 8'h11)  begin failures++; $display("FAIL first_q got=%h exp=11", q_a); end
  endtask

  task automatic test_manual();
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      tick();
      checks++; if (q_a !== exp_q[i]) begin failures++; $display("FAIL manual_q[%0d] got=%h exp=%h", i, q_a, exp_q[i]); end
      checks++; if (c_a !== 2'(i))    begin failures++; $display("FAIL manual_qch[%0d] got=%0d exp=%0d", i, c_a, i); end
      checks++; if (v_a !== 1'b1 || e_a !== 1'b0) begin failures++; $display("FAIL manual_flags[%0d] got v=%b e=%b exp v=1 e=0", i, v_a, e_a); end
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_ch [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel_a = 2'd2;
    tick();
    checks++; if (c_a !== 2'd2) begin failures++; $display("FAIL pre_switch_qch got=%0d exp=2", c_a); end
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (c_a !== exp_ch[i]) begin failures++; $display("FAIL scan_qch[%0d] got=%0d exp=%0d", i, c_a, exp_ch[i]); end
      checks++; if (q_a !== dat[exp_ch[i]]) begin failures++; $display("FAIL scan_q[%0d] got=%h exp=%h", i, q_a, dat[exp_ch[i]]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_ch [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick();
    checks++; if (c_a !== 2'd1 || q_a !== 8'h22) begin failures++; $display("FAIL bp_pre got ch=%0d q=%h exp ch=1 q=22", c_a, q_a); end
    out_ready = 1'b0;
    d_a = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q_a !== 8'h22 || c_a !== 2'd1 || v_a !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got q=%h ch=%0d v=%b exp q=22 ch=1 v=1", i, q_a, c_a, v_a); end
    end
    d_a = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (c_a !== exp_ch[i] || q_a !== dat[exp_ch[i]]) begin
        failures++; $display("FAIL bp_resume[%0d] got ch=%0d q=%h exp ch=%0d q=%h", i, c_a, q_a, exp_ch[i], dat[exp_ch[i]]); end
    end
  endtask

  task automatic test_sel_err();
    mode = 1'b0; sel_b = 2'd3;
    tick();
    checks++; if (q_b !== 8'hA1) begin failures++; $display("FAIL selerr_q got=%h exp=a1", q_b); end
    checks++; if (c_b !== 2'd3)  begin failures++; $display("FAIL selerr_qch got=%0d exp=3", c_b); end
    checks++; if (e_b !== 1'b1)  begin failures++; $display("FAIL selerr_flag got=%b exp=1", e_b); end
    sel_b = 2'd1;
    tick();
    checks++; if (q_b !== 8'hB2 || c_b !== 2'd1 || e_b !== 1'b0) begin
      failures++; $display("FAIL selerr_clear got q=%h ch=%0d e=%b exp q=b2 ch=1 e=0", q_b, c_b, e_b); end
  endtask

  task automatic test_parity();
    sel_a = 2'd0;
    d_a = {8'h44, 8'h33, 8'h22, 8'h07};
    tick();
    checks++; if (q_a !== 8'h07) begin failures++; $display("FAIL par_q07 got=%h exp=07", q_a); end
`ifdef MUXN_PARITY_EN
    checks++; if (p_a !== 1'b1) begin failures++; $display("FAIL par_07 got=%b exp=1", p_a); end
`endif
    d_a = {8'h44, 8'h33, 8'h22, 8'h03};
    tick();
    checks++; if (q_a !== 8'h03) begin failures++; $display("FAIL par_q03 got=%h exp=03", q_a); end
`ifdef MUXN_PARITY_EN
    checks++; if (p_a !== 1'b0) begin failures++; $display("FAIL par_03 got=%b exp=0", p_a); end
`endif
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick();
    checks++; if (v_a !== 1'b1 || q_a !== 8'h03) begin failures++; $display("FAIL mid_hold got v=%b q=%h exp v=1 q=03", v_a, q_a); end
    reset = 1'b1;
    tick();
    checks++; if (v_a !== 1'b0 || q_a !== 8'h00 || c_a !== 2'd0) begin
      failures++; $display("FAIL mid_reset got v=%b q=%h ch=%0d exp v=0 q=00 ch=0", v_a, q_a, c_a); end
    reset = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (v_a !== 1'b0) begin failures++; $display("FAIL mid_idle got v=%b exp=0", v_a); end
    tick();
    checks++; if (v_a !== 1'b1 || q_a !== 8'h03) begin failures++; $display("FAIL mid_restart got v=%b q=%h exp v=1 q=03", v_a, q_a); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_sel_err();
    test_parity();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
